select_encode_sb: RTL

- Parametrised successor to the register select/encode logic of the 32-bit datapath.
- Holds the current instruction in an internal IR and decodes opcode, Ra/Rb/Rc and the sign-extended C constant from it.
- Drives one-hot register-file enables using Gra/Grb/Grc priority selection.
- Adds a write-pending scoreboard and a valid/ready issue handshake, so read-after-write hazards stall decoding until writeback.

---
 rtl/select_encode_sb.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/select_encode_sb.sv
// select_encode_sb: instruction register, field decode, gra/grb/grc register
// select with one-hot enables, write-pending scoreboard and valid/ready issue.
// Optional build macro SB_WB_BYPASS_EN: a same-cycle writeback to a source
// register counts as already cleared in the hazard check.
module select_encode_sb #(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4,
    parameter int IR_W     = 32,
    parameter int OPC_W    = 5,
    parameter int IMM_W    = 19
) (
    input  logic                clock,
    input  logic                clear,
    input  logic [IR_W-1:0]     ir_in,
    input  logic                ir_valid,
    input  logic                use_rb,
    input  logic                use_rc,
    input  logic                writes_ra,
    output logic                ir_ready,
    input  logic                done,
    input  logic                gra,
    input  logic                grb,
    input  logic                grc,
    input  logic                rin,
    input  logic                rout,
    input  logic                baout,
    input  logic                wb_valid,
    input  logic [ADDR_W-1:0]   wb_addr,
    output logic [OPC_W-1:0]    opcode,
    output logic [IR_W-1:0]     c_sign_extended,
    output logic [NUM_REGS-1:0] reg_in,
    output logic [NUM_REGS-1:0] reg_out,
    output logic                hazard,
    output logic                sel_error,
    output logic [NUM_REGS-1:0] pending
);

    // Register fields sit directly below the opcode, MSB first.
    localparam int RA_HI = IR_W - OPC_W - 1;
    localparam int RB_HI = RA_HI - ADDR_W;
    localparam int RC_HI = RB_HI - ADDR_W;

    // Parameter sanity: the register field must address exactly NUM_REGS.
    if (ADDR_W != $clog2(NUM_REGS) || (NUM_REGS & (NUM_REGS - 1)) != 0) begin : g_bad_params
        $error("select_encode_sb: NUM_REGS must be a power of 2 and ADDR_W = log2(NUM_REGS)");
    end

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        STALL = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IR_W-1:0]     ir_q, ir_d;
    logic                use_rb_q, use_rb_d;
    logic                use_rc_q, use_rc_d;
    logic                wr_ra_q, wr_ra_d;
    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic                hazard_q;

    logic                accept;
    logic                pend_set;
    logic [ADDR_W-1:0]   set_addr;
    logic                busy_in, busy_held;

    // Decoded fields of the offered and the held instruction.
    logic [ADDR_W-1:0]   ra_in, rb_in, rc_in;
    logic [ADDR_W-1:0]   ra_q, rb_q, rc_q;

    assign ra_in = ir_in[RA_HI -: ADDR_W];
    assign rb_in = ir_in[RB_HI -: ADDR_W];
    assign rc_in = ir_in[RC_HI -: ADDR_W];
    assign ra_q  = ir_q[RA_HI -: ADDR_W];
    assign rb_q  = ir_q[RB_HI -: ADDR_W];
    assign rc_q  = ir_q[RC_HI -: ADDR_W];

    assign opcode          = ir_q[IR_W-1 -: OPC_W];
    assign c_sign_extended = {{(IR_W-IMM_W){ir_q[IMM_W-1]}}, ir_q[IMM_W-1:0]};

    // A source is busy when its pending bit is set; with the bypass build a
    // writeback landing on it this cycle already counts as cleared.
    function automatic logic src_busy(input logic [NUM_REGS-1:0] pend,
                                      input logic [ADDR_W-1:0]   addr,
                                      input logic                wbv,
                                      input logic [ADDR_W-1:0]   wba);
`ifdef SB_WB_BYPASS_EN
        return pend[addr] & ~(wbv & (wba == addr));
`else
        return pend[addr] & ~(wbv & 1'b0) & ~(|(wba & '0));
`endif
    endfunction

    assign busy_in   = (use_rb   & src_busy(pending_q, rb_in, wb_valid, wb_addr)) |
                       (use_rc   & src_busy(pending_q, rc_in, wb_valid, wb_addr));
    assign busy_held = (use_rb_q & src_busy(pending_q, rb_q,  wb_valid, wb_addr)) |
                       (use_rc_q & src_busy(pending_q, rc_q,  wb_valid, wb_addr));

    // Ready when empty, or when the held instruction finishes this cycle;
    // never during clear so nothing is taken while the block is resetting.
    assign ir_ready = ~clear & ((state_q == EMPTY) | ((state_q == HOLD) & done));
    assign accept   = ir_valid & ir_ready;

    // Next-state, IR capture and scoreboard set/clear decisions.
    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        use_rb_d = use_rb_q;
        use_rc_d = use_rc_q;
        wr_ra_d  = wr_ra_q;
        pend_set = 1'b0;
        set_addr = ra_q;
        if (accept) begin
            ir_d     = ir_in;
            use_rb_d = use_rb;
            use_rc_d = use_rc;
            wr_ra_d  = writes_ra;
            if (busy_in) begin
                state_d = STALL;
            end else begin
                state_d  = HOLD;
                pend_set = writes_ra;
                set_addr = ra_in;
            end
        end else begin
            case (state_q)
                STALL: begin
                    if (!busy_held) begin
                        state_d  = HOLD;
                        pend_set = wr_ra_q;
                        set_addr = ra_q;
                    end
                end
                HOLD: begin
                    if (done) state_d = EMPTY;
                end
                default: ;
            endcase
        end

        // Clear first so a same-cycle set of the same register wins.
        pending_d = pending_q;
        if (wb_valid) pending_d[wb_addr] = 1'b0;
        if (pend_set) pending_d[set_addr] = 1'b1;
    end

    // FSM, held instruction, scoreboard and registered hazard flag.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q   <= EMPTY;
            ir_q      <= '0;
            use_rb_q  <= 1'b0;
            use_rc_q  <= 1'b0;
            wr_ra_q   <= 1'b0;
            pending_q <= '0;
            hazard_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            use_rb_q  <= use_rb_d;
            use_rc_q  <= use_rc_d;
            wr_ra_q   <= wr_ra_d;
            pending_q <= pending_d;
            hazard_q  <= (state_d == STALL);
        end
    end

    assign hazard  = hazard_q;
    assign pending = pending_q;

    // Register select: Ra over Rb over Rc, register 0 when nothing selected.
    logic [ADDR_W-1:0]   sel_idx;
    logic [NUM_REGS-1:0] sel_oh;
    logic                hold_en;

    always_comb begin
        sel_idx = '0;
        if (gra)      sel_idx = ra_q;
        else if (grb) sel_idx = rb_q;
        else if (grc) sel_idx = rc_q;
    end

    assign sel_oh    = {{(NUM_REGS-1){1'b0}}, 1'b1} << sel_idx;
    assign sel_error = (gra & grb) | (gra & grc) | (grb & grc);
    assign hold_en   = (state_q == HOLD);
    assign reg_in    = sel_oh & {NUM_REGS{rin & hold_en}};
    assign reg_out   = sel_oh & {NUM_REGS{(rout | baout) & hold_en}};

endmodule
